// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             busy_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow_out,
`endif
  output logic [1:0]       state_dbg_out
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Operands transfer in IDLE (ready_out), results transfer in HOLD (valid_out && ready_in).

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bit_d, br_nxt, last_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  assign bit_d    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign br_nxt   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = RUN;
      RUN:     if (last_bit) state_d = HOLD;
      HOLD:    if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    if (state_q == IDLE && valid_in) begin
      a_sr_d = a_in;
      b_sr_d = b_in;
      br_d   = borrow_in;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = {bit_d, res_sr_q[WIDTH-1:1]};
      br_d     = br_nxt;
      cnt_d    = cnt_q + CW'(1);
      // Only final results reach diff_out; partial bits stay in res_sr.
      if (last_bit) begin
        diff_d   = {bit_d, res_sr_q[WIDTH-1:1]};
        borrow_d = br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d    = br_q ^ br_nxt;
`endif
      end
    end
  end

  always_comb begin
    ready_out     = (state_q == IDLE);
    busy_out      = (state_q == RUN);
    valid_out     = (state_q == HOLD);
    diff_out      = diff_q;
    borrow_out    = borrow_q;
    state_dbg_out = state_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    overflow_out  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=8 with hand-computed results.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       v4, r4o, bi4, vo4, ri4, bo4, busy4;
  logic [3:0] a4, b4, d4;
  logic [1:0] st4;
  logic       v8, r8o, bi8, vo8, ri8, bo8, busy8;
  logic [7:0] a8, b8, d8;
  logic [1:0] st8;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf4, ovf8;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(v4), .ready_out(r4o),
    .a_in(a4), .b_in(b4), .borrow_in(bi4), .valid_out(vo4), .ready_in(ri4),
    .diff_out(d4), .borrow_out(bo4), .busy_out(busy4),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow_out(ovf4),
`endif
    .state_dbg_out(st4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(v8), .ready_out(r8o),
    .a_in(a8), .b_in(b8), .borrow_in(bi8), .valid_out(vo8), .ready_in(ri8),
    .diff_out(d8), .borrow_out(bo8), .busy_out(busy8),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow_out(ovf8),
`endif
    .state_dbg_out(st8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bi,
                      input logic [3:0] ed, input logic eb, input logic eo, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(r4o), 32'd1);
    v4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
    @(posedge clk); #1;
    v4 = 1'b0; a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
    check({tag, "_busy"}, 32'({busy4, r4o}), 32'b10);
    lat = 0;
    while (!vo4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(d4), 32'(ed));
    check({tag, "_borrow"}, 32'(bo4), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(ovf4), 32'(eo));
`else
    if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      v4 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check({tag, "_hold"}, 32'({vo4, r4o, d4, bo4}), 32'({1'b1, 1'b0, ed, eb}));
    end
    v4 = 1'b0; ri4 = 1'b1;
    @(posedge clk); #1;
    ri4 = 1'b0;
    check({tag, "_release"}, 32'({vo4, r4o, d4}), 32'({1'b0, 1'b1, ed}));
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input int hold);
    int lat;
    @(negedge clk);
    v8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    lat = 0;
    while (!vo8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_result"}, 32'({bo8, d8}), 32'({eb, ed}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, 32'({vo8, bo8, d8}), 32'({1'b1, eb, ed}));
    end
    ri8 = 1'b1;
    @(posedge clk); #1;
    ri8 = 1'b0;
    check({tag, "_release"}, 32'({vo8, r8o}), 32'b01);
  endtask

  logic [7:0] tbl_a [10] = '{8'd200, 8'd100, 8'd0,   8'd255, 8'd255, 8'd0,   8'd128, 8'h5A, 8'd1,   8'h80};
  logic [7:0] tbl_b [10] = '{8'd100, 8'd200, 8'd0,   8'd255, 8'd0,   8'd255, 8'd1,   8'hA5, 8'd1,   8'h80};
  logic       tbl_i [10] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,  1'b1,   1'b1};
  logic [7:0] tbl_d [10] = '{8'h64,  8'h9C,  8'hFF,  8'h00,  8'hFE,  8'h01,  8'h7F,  8'hB4, 8'hFF,  8'hFF};
  logic       tbl_b_o [10] = '{1'b0, 1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,  1'b1,   1'b1};

  initial begin
    rst_n = 1'b0;
    v4 = 0; a4 = 0; b4 = 0; bi4 = 0; ri4 = 0;
    v8 = 0; a8 = 0; b8 = 0; bi8 = 0; ri8 = 0;
    #2;
    check("reset_outputs", 32'({r4o, vo4, busy4, bo4, d4}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
    check("reset_outputs8", 32'({r8o, vo8, busy8, bo8, d8}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h0}));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("reset_ovf", 32'(ovf4), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run4("sub_9_3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, 0);
    run4("sub_3_9_bp", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 10);
    run4("sub_0_0_1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 2);

    // Abort an operation two cycles in, with reset landing between clock edges.
    @(negedge clk);
    v4 = 1'b1; a4 = 4'hC; b4 = 4'h3; bi4 = 1'b0;
    @(posedge clk); #1;
    v4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({r4o, vo4, busy4, bo4, d4}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    run4("after_rst_5_5", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1);

`ifdef SERIAL_SUB_OVERFLOW_EN
    run4("ovf_7_f", 4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 0);
    run4("ovf_8_1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 0);
    run4("ovf_2_1", 4'h2, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      run8($sformatf("w8_vec%0d", i), tbl_a[i], tbl_b[i], tbl_i[i], tbl_d[i], tbl_b_o[i],
           int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; the inverse-operation companion of the team's ripple-carry adder datapath.
- Computes diff = a - b - borrow_in, processing one bit per clock, LSB first, through a single borrow flip-flop.
- Has a valid/ready handshake on both the operand side and the result side.
- Used where area matters more than latency, e.g. counters and comparators in slow control paths.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- valid_in  input  1  operands on a_in/b_in/borrow_in are valid.
- ready_out  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  minuend.
- b_in  input  WIDTH  subtrahend.
- borrow_in  input  1  borrow input, weight 1.
- valid_out  output  1  diff_out/borrow_out hold a valid result.
- ready_in  input  1  downstream accepts the result.
- diff_out  output  WIDTH  difference, modulo 2^WIDTH.
- borrow_out  output  1  borrow from the MSB; 1 when a < b + borrow_in (unsigned).
- busy_out  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock, clk_in; reset is asynchronous and active-low, rst_n_in.
- Reset values:
  - state = IDLE.
  - ready_out = 1, valid_out = 0, busy_out = 0.
  - diff_out = 0, borrow_out = 0.
  - Internal shift registers, bit counter and borrow FF are all cleared.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - ready_out = 1.
  - Acceptance: on the edge where valid_in && ready_out, latch a_in and b_in into shift registers, load the borrow FF with borrow_in, clear the bit counter, and go to RUN.
  - Operand values are ignored when valid_in is low.
- RUN:
  - Each edge: d = a[0] ^ b[0] ^ br; br_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br).
  - Shift d into the result register MSB-ward so the LSB lands at bit 0 after WIDTH shifts. Shift both operand registers right. Increment the counter.
  - After the WIDTH-th shift, go to HOLD. The counter must not wrap before this; the counter width is clog2(WIDTH)+1.
- HOLD:
  - valid_out = 1. diff_out and borrow_out are stable and equal the final result.
  - On an edge with ready_in = 1, go to IDLE and deassert valid_out.
  - diff_out and borrow_out keep their last value until the next result is loaded.
- Latency: valid_out rises exactly WIDTH clock edges after the acceptance edge.
- Throughput: one result per WIDTH+2 cycles minimum, with one IDLE cycle between results.
- Intermediate visibility: diff_out shows only final results. Partial bits live in an internal register and are copied to diff_out on the RUN→HOLD edge.
- Operand stability: valid_in and operand changes during RUN or HOLD have no effect on the result in flight; ready_out = 0 in those states.
- Backpressure: HOLD persists indefinitely while ready_in = 0.
- Reset mid-operation: rst_n_in low in any state forces the reset values immediately, with no clock required. The in-flight result is discarded.
- Unsigned identity: {borrow_out, diff_out} = a - b - borrow_in taken modulo 2^(WIDTH+1), i.e. borrow_out = 1 exactly when a < b + borrow_in.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Adds output port overflow_out, 1 bit, reset 0, loaded on the RUN→HOLD edge alongside diff_out.
  - overflow_out = 1 when the signed (two's-complement) result is not representable: sign(a) != sign(b) and sign(diff) != sign(a).
  - Implemented as borrow-into-MSB XOR borrow-out-of-MSB.
- Not defined: the port does not exist; no extra flops.

Test Plan:
- WIDTH=4, a=9, b=3, borrow_in=0 → after 4 edges valid_out=1, diff_out=6, borrow_out=0; ready_in=1 → IDLE the next edge, ready_out=1.
- WIDTH=4, a=3, b=9, borrow_in=0 → diff_out=4'hA, borrow_out=1. Also a=0, b=0, borrow_in=1 → diff_out=4'hF, borrow_out=1.
- Backpressure: hold ready_in=0 for 10 cycles in HOLD → valid_out and diff_out stable; toggle valid_in and a_in meanwhile → no effect; ready_out=0 throughout.
- Reset mid-operation: assert rst_n_in low 2 cycles after acceptance, asynchronous to the clock → outputs go to reset values immediately. The next operation, a=5, b=5, borrow_in=0, gives diff_out=0, borrow_out=0.
- WIDTH=8: exhaustive a, b in 0..255 with random borrow_in and random ready_in delays → {borrow_out, diff_out} matches the reference model; latency is exactly 8 edges every time.
- SERIAL_SUB_OVERFLOW_EN defined, WIDTH=4:
  - a=4'h7, b=4'hF → diff_out=4'h8, overflow_out=1.
  - a=4'h8, b=4'h1 → diff_out=4'h7, overflow_out=1.
  - a=4'h2, b=4'h1 → overflow_out=0.
